// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, LSB-first data, optional parity, one stop bit.
// Every bit lasts PRESCALE clocks; tx_out and busy come straight from flops.
module uart_tx_framer #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  tx_out,
    output logic                  busy
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  pe_q, pe_d;
    logic                  pt_q, pt_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            pe_q    <= 1'b0;
            pt_q    <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            pe_q    <= pe_d;
            pt_q    <= pt_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        pe_d    = pe_q;
        pt_d    = pt_q;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        wrap    = (cnt_q == CNT_MAX);

        if (state_q == IDLE) begin
            cnt_d = '0;
        end else begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (data_valid) begin
                    state_d = START;
                    data_d  = p_data;
                    pe_d    = par_en;
                    pt_d    = par_typ;
                end
            end
            START: begin
                if (wrap) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (wrap) begin
                    if (idx_q == IDX_MAX) begin
                        idx_d   = '0;
                        state_d = pe_q ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (wrap) state_d = STOP;
            end
            STOP: begin
                if (wrap) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase

        // Output flops load the level of the bit being entered, so the
        // line changes on the same edge as the state.
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_d[idx_d];
            PARITY:  tx_d = (^data_d) ^ pt_d;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign tx_out = tx_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer with DATA_WIDTH=8, PRESCALE=8.
// Outputs are sampled on the falling edge, one sample per clock.
module tb_uart_tx_framer;

    localparam int P  = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] p_data;
    logic          data_valid;
    logic          par_en;
    logic          par_typ;
    logic          tx_out;
    logic          busy;

    int   compared   = 0;
    int   mismatched = 0;
    logic tx_s   [0:255];
    logic busy_s [0:255];

    uart_tx_framer #(.DATA_WIDTH(DW), .PRESCALE(P)) dut (
        .clk       (clk),
        .rst       (rst),
        .p_data    (p_data),
        .data_valid(data_valid),
        .par_en    (par_en),
        .par_typ   (par_typ),
        .tx_out    (tx_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic start_frame(input logic [DW-1:0] d, input logic pe,
                               input logic pt);
        @(negedge clk);
        p_data = d; par_en = pe; par_typ = pt; data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            tx_s[i]   = tx_out;
            busy_s[i] = busy;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; data_valid = 1'b0; p_data = '0;
        par_en = 1'b0; par_typ = 1'b0;
        #12;
        compared++;
        if (tx_out !== 1'b1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_state: tx_out=%b busy=%b, expected 1/0", tx_out, busy);
        end
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
        compared++;
        if (tx_out !== 1'b1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL idle_after_reset: tx_out=%b busy=%b, expected 1/0", tx_out, busy);
        end
    endtask

    task automatic test_no_parity();
        logic [10:0] exp;
        int bc;
        exp = {1'b0, 1'b1, 8'hA5, 1'b0};
        start_frame(8'hA5, 1'b0, 1'b0);
        capture(84);
        for (int b = 0; b < 10; b++) begin
            int bad = -1;
            for (int c = 0; c < P; c++) if (tx_s[b*P+c] !== exp[b]) bad = c;
            compared++;
            if (bad >= 0) begin
                mismatched++;
                $display("FAIL nopar_bit%0d: tx_out=%b at cycle %0d, expected %b",
                         b, tx_s[b*P+bad], b*P+bad, exp[b]);
            end
        end
        bc = 0;
        for (int i = 0; i < 84; i++) bc += int'(busy_s[i]);
        compared++;
        if (bc != 80 || busy_s[0] !== 1'b1 || busy_s[79] !== 1'b1) begin
            mismatched++;
            $display("FAIL nopar_busy_len: busy cycles=%0d, expected 80", bc);
        end
        compared++;
        if (tx_s[80] !== 1'b1 || tx_s[83] !== 1'b1) begin
            mismatched++;
            $display("FAIL nopar_idle_after: tx_out=%b%b, expected 11", tx_s[80], tx_s[83]);
        end
    endtask

    task automatic test_parity(input logic pt, input logic par_exp);
        logic [10:0] exp;
        int bc;
        exp = {1'b1, par_exp, 8'h07, 1'b0};
        start_frame(8'h07, 1'b1, pt);
        capture(92);
        for (int b = 0; b < 11; b++) begin
            int bad = -1;
            for (int c = 0; c < P; c++) if (tx_s[b*P+c] !== exp[b]) bad = c;
            compared++;
            if (bad >= 0) begin
                mismatched++;
                $display("FAIL par%0d_bit%0d: tx_out=%b at cycle %0d, expected %b",
                         pt, b, tx_s[b*P+bad], b*P+bad, exp[b]);
            end
        end
        bc = 0;
        for (int i = 0; i < 92; i++) bc += int'(busy_s[i]);
        compared++;
        if (bc != 88 || busy_s[0] !== 1'b1 || busy_s[87] !== 1'b1) begin
            mismatched++;
            $display("FAIL par%0d_busy_len: busy cycles=%0d, expected 88", pt, bc);
        end
    endtask

    task automatic test_ignore_busy();
        logic [10:0] exp;
        int bc;
        exp = {1'b0, 1'b1, 8'hC3, 1'b0};
        start_frame(8'hC3, 1'b0, 1'b0);
        for (int i = 0; i < 110; i++) begin
            tx_s[i]   = tx_out;
            busy_s[i] = busy;
            if (i == 26) begin
                data_valid = 1'b1; p_data = 8'hFF; par_en = 1'b1;
            end
            if (i == 30) par_en = 1'b0;
            if (i == 34) par_en = 1'b1;
            if (i == 60) begin
                data_valid = 1'b0; par_en = 1'b0;
            end
            @(negedge clk);
        end
        for (int b = 0; b < 10; b++) begin
            int bad = -1;
            for (int c = 0; c < P; c++) if (tx_s[b*P+c] !== exp[b]) bad = c;
            compared++;
            if (bad >= 0) begin
                mismatched++;
                $display("FAIL ignore_bit%0d: tx_out=%b at cycle %0d, expected %b",
                         b, tx_s[b*P+bad], b*P+bad, exp[b]);
            end
        end
        bc = 0;
        for (int i = 0; i < 110; i++) bc += int'(busy_s[i]);
        compared++;
        if (bc != 80 || busy_s[79] !== 1'b1 || busy_s[80] !== 1'b0) begin
            mismatched++;
            $display("FAIL ignore_busy_len: busy cycles=%0d, expected 80", bc);
        end
        bc = 0;
        for (int i = 80; i < 110; i++) bc += int'(!tx_s[i]);
        compared++;
        if (bc != 0) begin
            mismatched++;
            $display("FAIL ignore_no_second: low tx cycles after frame=%0d, expected 0", bc);
        end
    endtask

    task automatic test_async_reset();
        logic [10:0] exp;
        int bc;
        start_frame(8'h96, 1'b0, 1'b0);
        repeat (35) @(negedge clk);
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_pre_busy: busy=%b, expected 1", busy);
        end
        #2 rst = 1'b1;
        #1;
        compared++;
        if (tx_out !== 1'b1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_async: tx_out=%b busy=%b, expected 1/0", tx_out, busy);
        end
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
        exp = {1'b0, 1'b1, 8'h3C, 1'b0};
        start_frame(8'h3C, 1'b0, 1'b0);
        capture(84);
        for (int b = 0; b < 10; b++) begin
            int bad = -1;
            for (int c = 0; c < P; c++) if (tx_s[b*P+c] !== exp[b]) bad = c;
            compared++;
            if (bad >= 0) begin
                mismatched++;
                $display("FAIL rst_after_bit%0d: tx_out=%b at cycle %0d, expected %b",
                         b, tx_s[b*P+bad], b*P+bad, exp[b]);
            end
        end
        bc = 0;
        for (int i = 0; i < 84; i++) bc += int'(busy_s[i]);
        compared++;
        if (bc != 80) begin
            mismatched++;
            $display("FAIL rst_after_busy_len: busy cycles=%0d, expected 80", bc);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] exp;
        exp = {1'b0, 1'b1, 8'h55, 1'b0};
        @(negedge clk);
        p_data = 8'h55; par_en = 1'b0; par_typ = 1'b0; data_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 170; i++) begin
            tx_s[i]   = tx_out;
            busy_s[i] = busy;
            if (i == 161) data_valid = 1'b0;
            @(negedge clk);
        end
        for (int f = 0; f < 2; f++) begin
            for (int b = 0; b < 10; b++) begin
                int bad = -1;
                int base = f*81 + b*P;
                for (int c = 0; c < P; c++) if (tx_s[base+c] !== exp[b]) bad = c;
                for (int c = 0; c < P; c++) if (busy_s[base+c] !== 1'b1) bad = c;
                compared++;
                if (bad >= 0) begin
                    mismatched++;
                    $display("FAIL b2b_f%0d_bit%0d: tx_out=%b busy=%b at cycle %0d, expected %b/1",
                             f, b, tx_s[base+bad], busy_s[base+bad], base+bad, exp[b]);
                end
            end
        end
        compared++;
        if (tx_s[80] !== 1'b1 || busy_s[80] !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_gap: tx_out=%b busy=%b, expected 1/0", tx_s[80], busy_s[80]);
        end
        compared++;
        if (tx_s[81] !== 1'b0 || busy_s[81] !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_restart: tx_out=%b busy=%b, expected 0/1", tx_s[81], busy_s[81]);
        end
        compared++;
        if (tx_s[161] !== 1'b1 || busy_s[161] !== 1'b0 || busy_s[169] !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_end: tx_out=%b busy=%b, expected 1/0", tx_s[161], busy_s[169]);
        end
    endtask

    initial begin
        test_reset();
        test_no_parity();
        test_parity(1'b0, 1'b1);
        test_parity(1'b1, 1'b0);
        test_ignore_busy();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
UART transmitter that serialises one parallel word into an asynchronous frame: start bit, DATA_WIDTH data bits LSB first, optional parity bit, one stop bit. Each bit is held on the line for PRESCALE clock cycles. It is the transmit counterpart of the receiver's oversampling edge/bit-counting logic and uses the same ticks-per-bit convention. It sits between the host-side data source and the serial TX pin.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (5..9)
PRESCALE, 8, clock cycles per serial bit (>=2); matches the receiver oversample factor

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
p_data  input  DATA_WIDTH  parallel word to send
data_valid  input  1  request to send p_data; sampled only when busy=0
par_en  input  1  1 = insert parity bit after data
par_typ  input  1  0 = even parity, 1 = odd parity
tx_out  output  1  serial line, idle high, registered
busy  output  1  high while a frame is in progress, registered

Behaviour:
- Reset (async, rst=1): tx_out=1, busy=0, FSM=IDLE, prescale counter=0, bit index=0, holding registers cleared. Takes effect immediately, including mid-frame; line returns to idle-high with no partial stop bit.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx_out=1, busy=0. At a rising edge with data_valid=1: latch p_data, par_en, par_typ into holding registers; go to START. At that same edge, tx_out becomes 0 and busy becomes 1 (zero cycles of latency from acceptance to start bit).
- Prescale counter: counts 0..PRESCALE-1 in every non-IDLE state; wraps to 0 at the bit boundary. Each state transition occurs only at the wrap, so every bit is exactly PRESCALE cycles.
- START: tx_out=0 for PRESCALE cycles, then DATA with bit index 0.
- DATA: tx_out = latched data[bit index]. At each bit boundary, increment bit index. After bit DATA_WIDTH-1, go to PARITY if latched par_en=1, else STOP. Bit index resets to 0 on leaving DATA.
- PARITY: tx_out = XOR of all latched data bits, inverted when latched par_typ=1. Held PRESCALE cycles, then STOP.
- STOP: tx_out=1 for PRESCALE cycles, then IDLE with busy=0.
- Frame length with busy=1 is exactly PRESCALE*(DATA_WIDTH+2+par_en) cycles.
- While busy=1, data_valid is ignored and no request is queued. Changes to p_data, par_en or par_typ do not affect the frame in flight.
- Back-to-back: a frame can only be accepted in IDLE, so at least one idle-high cycle (busy=0) separates consecutive frames. With data_valid held high, the gap is exactly one cycle.
- Outputs are driven only from registers: no glitches and no combinational path from inputs to tx_out or busy.
- Counter widths: prescale counter ceil(log2(PRESCALE)) bits; bit index ceil(log2(DATA_WIDTH)) bits. Neither counter may overflow past its terminal value.

Test Plan:
- PRESCALE=8, par_en=0, p_data=0xA5, one-cycle data_valid -> tx_out bits 0,1,0,1,0,0,1,0,1,1, each held 8 cycles; busy high exactly 80 cycles; tx_out=1 afterwards.
- par_en=1, par_typ=0, p_data=0x07 -> parity bit = 1; busy high 88 cycles; stop bit = 1.
- par_en=1, par_typ=1, p_data=0x07 -> parity bit = 0; every other bit identical to the previous case.
- During data bit 2, assert data_valid with p_data=0xFF and toggle par_en -> in-flight frame unchanged; no second frame follows; busy drops after the original frame length.
- Assert rst during data bit 3 -> tx_out=1 and busy=0 immediately, without waiting for a clock edge. After release, data_valid with p_data=0x3C sends a complete, correct frame.
- data_valid held high with p_data=0x55 -> consecutive frames separated by exactly one cycle of tx_out=1 and busy=0; each frame bit-exact.
